spike_out_arbiter: RTL

- Merges the per-column on/off spike outputs of the nn array (NUM_COLS columns) into one timestamped event stream with a valid/ready handshake.
- Sits between the nn column outputs and the consumers: the external spike router and the monitor/readout.
- Holds one pending event per column, grants columns round-robin, and counts events dropped on slot collision.

---
 rtl/spike_out_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/spike_out_arbiter.sv
// Merges per-column on/off spikes into one timestamped valid/ready event stream.
// One pending slot per column, round-robin grant, saturating count of colliding spikes.
module spike_out_arbiter #(
  parameter int NUM_COLS  = 4,
  parameter int TS_WIDTH  = 16,
  parameter int CNT_WIDTH = 8,
  parameter int COL_WIDTH = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [NUM_COLS-1:0]  spike_valid,
  input  logic [NUM_COLS-1:0]  spike_on_off,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [COL_WIDTH-1:0] out_col,
  output logic                 out_on_off,
  output logic [TS_WIDTH-1:0]  out_timestamp,
  input  logic                 clear_drops,
  output logic [CNT_WIDTH-1:0] drop_count,
  output logic                 drop_pulse
);

  localparam int SUM_W = CNT_WIDTH + COL_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [COL_WIDTH:0]   NCOLS_W  = (COL_WIDTH+1)'(NUM_COLS);
  localparam logic [COL_WIDTH-1:0] LAST_COL = COL_WIDTH'(NUM_COLS - 1);

  logic [NUM_COLS-1:0]  slot_vld_q, slot_vld_d;
  logic [NUM_COLS-1:0]  slot_pol_q, slot_pol_d;
  logic [TS_WIDTH-1:0]  slot_ts_q [NUM_COLS];
  logic [TS_WIDTH-1:0]  slot_ts_d [NUM_COLS];
  logic [TS_WIDTH-1:0]  ts_q, ts_d;
  logic [COL_WIDTH-1:0] ptr_q, ptr_d;
  logic                 out_valid_q, out_valid_d;
  logic [COL_WIDTH-1:0] out_col_q, out_col_d;
  logic                 out_pol_q, out_pol_d;
  logic [TS_WIDTH-1:0]  out_ts_q, out_ts_d;
  logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
  logic                 drop_pulse_q, drop_pulse_d;

  logic                 load_ok;
  logic                 grant_any;
  logic [COL_WIDTH-1:0] grant_idx;
  logic [COL_WIDTH:0]   idx_w;
  logic [NUM_COLS-1:0]  gnt_hot;
  logic [NUM_COLS-1:0]  cap;
  logic [NUM_COLS-1:0]  drop;
  logic [SUM_W-1:0]     drop_n;

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [SUM_W-1:0] b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + b;
    if (s > SUM_W'(CNT_MAX)) return CNT_MAX;
    return s[CNT_WIDTH-1:0];
  endfunction

  assign load_ok = !out_valid_q || out_ready;

  // Round-robin scan: walk downward so the last hit is the first valid slot at/after ptr.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    idx_w     = '0;
    for (int k = NUM_COLS - 1; k >= 0; k--) begin
      idx_w = {1'b0, ptr_q} + (COL_WIDTH+1)'(k);
      if (idx_w >= NCOLS_W) idx_w = idx_w - NCOLS_W;
      if (slot_vld_q[idx_w[COL_WIDTH-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = idx_w[COL_WIDTH-1:0];
      end
    end
    gnt_hot = '0;
    if (load_ok && grant_any) gnt_hot[grant_idx] = 1'b1;
  end

  // A slot being granted this cycle can take a new spike without a collision.
  always_comb begin
    cap    = '0;
    drop   = '0;
    drop_n = '0;
    for (int i = 0; i < NUM_COLS; i++) begin
      cap[i]  = spike_valid[i] && enable && (!slot_vld_q[i] || gnt_hot[i]);
      drop[i] = spike_valid[i] && enable && slot_vld_q[i] && !gnt_hot[i];
      drop_n  = drop_n + SUM_W'(drop[i]);
    end
  end

  always_comb begin
    slot_vld_d  = slot_vld_q;
    slot_pol_d  = slot_pol_q;
    slot_ts_d   = slot_ts_q;
    ts_d        = ts_q + TS_WIDTH'(1);
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_col_d   = out_col_q;
    out_pol_d   = out_pol_q;
    out_ts_d    = out_ts_q;
    if (load_ok) begin
      out_valid_d = grant_any;
      if (grant_any) begin
        out_col_d             = grant_idx;
        out_pol_d             = slot_pol_q[grant_idx];
        out_ts_d              = slot_ts_q[grant_idx];
        slot_vld_d[grant_idx] = 1'b0;
        ptr_d                 = (grant_idx == LAST_COL) ? '0 : grant_idx + COL_WIDTH'(1);
      end
    end
    for (int i = 0; i < NUM_COLS; i++) begin
      if (cap[i]) begin
        slot_vld_d[i] = 1'b1;
        slot_pol_d[i] = spike_on_off[i];
        slot_ts_d[i]  = ts_q;
      end
    end
    drop_cnt_d   = clear_drops ? '0 : sat_add(drop_cnt_q, drop_n);
    drop_pulse_d = |drop;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      slot_vld_q   <= '0;
      ts_q         <= '0;
      ptr_q        <= '0;
      out_valid_q  <= 1'b0;
      out_col_q    <= '0;
      out_pol_q    <= 1'b0;
      out_ts_q     <= '0;
      drop_cnt_q   <= '0;
      drop_pulse_q <= 1'b0;
    end else begin
      slot_vld_q   <= slot_vld_d;
      ts_q         <= ts_d;
      ptr_q        <= ptr_d;
      out_valid_q  <= out_valid_d;
      out_col_q    <= out_col_d;
      out_pol_q    <= out_pol_d;
      out_ts_q     <= out_ts_d;
      drop_cnt_q   <= drop_cnt_d;
      drop_pulse_q <= drop_pulse_d;
    end
  end

  // Slot payload is qualified by slot_vld_q, so it needs no reset.
  always_ff @(posedge clk) begin
    slot_pol_q <= slot_pol_d;
    slot_ts_q  <= slot_ts_d;
  end

  assign out_valid     = out_valid_q;
  assign out_col       = out_col_q;
  assign out_on_off    = out_pol_q;
  assign out_timestamp = out_ts_q;
  assign drop_count    = drop_cnt_q;
  assign drop_pulse    = drop_pulse_q;

endmodule
